// File: rtl/seq_store_param_if.sv
// rtl/seq_store_param_if.sv - push, playback and check handshake bundle for seq_store_param
interface seq_store_param_if #(
    parameter int DIGIT_W = 4
);
    logic               push;
    logic [DIGIT_W-1:0] push_digit;
    logic               play_start;
    logic               play_ready;
    logic               play_valid;
    logic [DIGIT_W-1:0] play_digit;
    logic               play_done;
    logic               chk_start;
    logic               chk_valid;
    logic [DIGIT_W-1:0] chk_digit;
    logic               chk_match;
    logic               chk_err;
    logic               chk_done;

    modport master (
        output push, push_digit, play_start, play_ready, chk_start, chk_valid, chk_digit,
        input  play_valid, play_digit, play_done, chk_match, chk_err, chk_done
    );

    modport slave (
        input  push, push_digit, play_start, play_ready, chk_start, chk_valid, chk_digit,
        output play_valid, play_digit, play_done, chk_match, chk_err, chk_done
    );
endinterface

// File: rtl/seq_store_param.sv
// rtl/seq_store_param.sv - parametrised digit sequence store with playback and entry checking
module seq_store_param #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 7,
    parameter int CNT_W   = 3
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     clear,
    seq_store_param_if.slave         bus,
    output logic                     overflow,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic [DIGIT_W*DEPTH-1:0] q
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t             state, state_n;
    logic [DIGIT_W-1:0] slot   [DEPTH];
    logic [DIGIT_W-1:0] slot_n [DEPTH];
    logic [CNT_W-1:0]   count_r, count_n;
    logic [CNT_W-1:0]   idx, idx_n;
    logic               play_valid_r, play_valid_n;
    logic [DIGIT_W-1:0] play_digit_r, play_digit_n;
    logic               play_done_r, play_done_n;
    logic               chk_match_r, chk_match_n;
    logic               chk_err_r, chk_err_n;
    logic               chk_done_r, chk_done_n;
    logic               overflow_r, overflow_n;
    logic               busy_r, busy_n;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
            count_r      <= '0;
            idx          <= '0;
            play_valid_r <= 1'b0;
            play_digit_r <= '0;
            play_done_r  <= 1'b0;
            chk_match_r  <= 1'b0;
            chk_err_r    <= 1'b0;
            chk_done_r   <= 1'b0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state        <= state_n;
            for (int i = 0; i < DEPTH; i++) slot[i] <= slot_n[i];
            count_r      <= count_n;
            idx          <= idx_n;
            play_valid_r <= play_valid_n;
            play_digit_r <= play_digit_n;
            play_done_r  <= play_done_n;
            chk_match_r  <= chk_match_n;
            chk_err_r    <= chk_err_n;
            chk_done_r   <= chk_done_n;
            overflow_r   <= overflow_n;
            busy_r       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        slot_n       = slot;
        count_n      = count_r;
        idx_n        = idx;
        play_valid_n = play_valid_r;
        play_digit_n = play_digit_r;
        play_done_n  = 1'b0;
        chk_match_n  = 1'b0;
        chk_err_n    = 1'b0;
        chk_done_n   = 1'b0;
        overflow_n   = 1'b0;

        if (clear) begin
            state_n = S_IDLE;
            for (int i = 0; i < DEPTH; i++) slot_n[i] = '0;
            count_n      = '0;
            idx_n        = '0;
            play_valid_n = 1'b0;
            play_digit_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A push in the same cycle as a start wins; the start is dropped.
                    if (bus.push) begin
                        for (int i = DEPTH - 1; i > 0; i--) slot_n[i] = slot[i-1];
                        slot_n[0] = bus.push_digit;
                        if (count_r == DEPTH_C) overflow_n = 1'b1;
                        else                    count_n    = count_r + ONE_C;
                    end else if (bus.play_start && count_r != '0) begin
                        state_n      = S_PLAY;
                        idx_n        = count_r - ONE_C;
                        play_valid_n = 1'b1;
                        play_digit_n = slot[count_r - ONE_C];
                    end else if (bus.chk_start && count_r != '0) begin
                        state_n = S_CHECK;
                        idx_n   = count_r - ONE_C;
                    end
                end
                S_PLAY: begin
                    if (play_valid_r && bus.play_ready) begin
                        if (idx == '0) begin
                            state_n      = S_IDLE;
                            play_valid_n = 1'b0;
                            play_digit_n = '0;
                            play_done_n  = 1'b1;
                        end else begin
                            idx_n        = idx - ONE_C;
                            play_digit_n = slot[idx - ONE_C];
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.chk_valid) begin
                        if (bus.chk_digit == slot[idx]) begin
                            chk_match_n = 1'b1;
                            if (idx == '0) begin
                                chk_done_n = 1'b1;
                                state_n    = S_IDLE;
                            end else begin
                                idx_n = idx - ONE_C;
                            end
                        end else begin
                            chk_err_n = 1'b1;
                            state_n   = S_IDLE;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

    assign bus.play_valid = play_valid_r;
    assign bus.play_digit = play_digit_r;
    assign bus.play_done  = play_done_r;
    assign bus.chk_match  = chk_match_r;
    assign bus.chk_err    = chk_err_r;
    assign bus.chk_done   = chk_done_r;
    assign overflow       = overflow_r;
    assign busy           = busy_r;
    assign count          = count_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_q
        assign q[g*DIGIT_W +: DIGIT_W] = slot[g];
    end

endmodule
